// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encodings,
// program-counter width, default reset PC and the RAM2 address/value widths.
package inst_fetch_pkg;

    localparam int PC_W        = 16;
    localparam int MEM_ADDR_W  = 18;
    localparam int MEM_VALUE_W = 16;

    // 16'hFFFF is reserved: it is the RAM2 controller's done-tag after reset.
    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    // Sequential PC advance; wraps 16'hFFFF back to 16'h0000.
    function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] pc);
        return pc + {{(PC_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/inst_queue.sv
// Two-entry FIFO holding {pc, instruction} pairs between fetch capture and
// the decode-facing outputs. Only built when INST_QUEUE_EN is defined.
`ifdef INST_QUEUE_EN
module inst_queue #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         push_ok;
    logic         pop_ok;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage, pointers and occupancy; flush empties the queue without
    // touching the stored words, which are unobservable once empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

endmodule
`endif

// File: rtl/inst_fetch.sv
// Instruction-fetch stage in front of the RAM2 controller. Owns the PC,
// issues instruction reads and hands one instruction per accepted fetch to
// decode. The PC is never changed while a RAM2 read may still be in flight.
// Optional build macro: INST_QUEUE_EN adds a 2-entry output FIFO so fetch
// keeps running while decode stalls.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int              ADDR_W   = MEM_ADDR_W,
    parameter int              DATA_W   = MEM_VALUE_W,
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              stall,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst,
    output logic [PC_W-1:0]   inst_pc,
    output logic [PC_W-1:0]   pc_out
);

    fetch_state_e    state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pending;
    logic            slot_free;
    logic            capture;

    assign mem_req  = (state != IDLE);
    assign mem_addr = {{(ADDR_W-PC_W){1'b0}}, pc};
    assign pc_out   = pc;

    // A redirect always suppresses capture so the flushed path is never loaded.
    assign capture = (state == FETCH) && mem_done && !redirect && slot_free;

    // Fetch FSM: PC advance, redirect handling and in-flight read draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            pending <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                    if (redirect) begin
                        pc <= redirect_pc;
                    end
                end
                FETCH: begin
                    if (redirect) begin
                        if (mem_done) begin
                            pc <= redirect_pc;
                        end else begin
                            pending <= redirect_pc;
                            state   <= DRAIN;
                        end
                    end else if (capture) begin
                        pc <= next_pc(pc);
                    end
                end
                DRAIN: begin
                    if (mem_done) begin
                        pc    <= redirect ? redirect_pc : pending;
                        state <= FETCH;
                    end else if (redirect) begin
                        pending <= redirect_pc;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef INST_QUEUE_EN
    logic                   q_full;
    logic                   q_empty;
    logic                   q_pop;
    logic [PC_W+DATA_W-1:0] q_head;

    assign slot_free  = !q_full;
    assign q_pop      = !q_empty && !stall && !redirect;
    assign inst_valid = !q_empty;
    assign inst_pc    = q_head[PC_W+DATA_W-1:DATA_W];
    assign inst       = q_head[DATA_W-1:0];

    inst_queue #(
        .W(PC_W + DATA_W)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (capture),
        .pop   (q_pop),
        .flush (redirect),
        .din   ({pc, mem_data}),
        .dout  (q_head),
        .full  (q_full),
        .empty (q_empty)
    );
`else
    assign slot_free = !inst_valid || !stall;

    // Single output register: load on capture, drop once decode takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
        end else if (redirect) begin
            inst_valid <= 1'b0;
        end else if (capture) begin
            inst       <= mem_data;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
        end else if (!stall) begin
            inst_valid <= 1'b0;
        end
    end
`endif

endmodule
